// File: rtl/write_command_control_pkg.sv
// rtl/write_command_control_pkg.sv - shared types and constants for the write command issue stage
package write_command_control_pkg;

    localparam logic [11:0] CACHELINE_SIZE = 12'd128;
    localparam logic [7:0]  RESP_DONE      = 8'h00;

    typedef logic [511:0] read_write_data_line_t;

    typedef struct packed {
        logic        valid;
        logic [7:0]  tag;
        logic [63:0] address;
        logic [11:0] size;
    } write_command_interface_t;

    typedef enum logic {
        INIT,
        RUN
    } write_state_t;

endpackage

// File: rtl/write_command_control_if.sv
// rtl/write_command_control_if.sv - request, command/data-buffer and response signals of the write issue stage
interface write_command_control_if;
    import write_command_control_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [63:0]           req_address;
    read_write_data_line_t req_data_0;
    read_write_data_line_t req_data_1;

    logic                  command_valid;
    logic [7:0]            command_tag;
    logic [63:0]           command_address;
    logic [11:0]           command_size;

    logic                  command_write_valid;
    logic [7:0]            command_tag_out;
    read_write_data_line_t write_data_0_out;
    read_write_data_line_t write_data_1_out;

    logic                  response_valid;
    logic [7:0]            response_tag;
    logic [7:0]            response_code;

    modport master (
        output req_valid, req_address, req_data_0, req_data_1,
        output response_valid, response_tag, response_code,
        input  req_ready,
        input  command_valid, command_tag, command_address, command_size,
        input  command_write_valid, command_tag_out, write_data_0_out, write_data_1_out
    );

    modport slave (
        input  req_valid, req_address, req_data_0, req_data_1,
        input  response_valid, response_tag, response_code,
        output req_ready,
        output command_valid, command_tag, command_address, command_size,
        output command_write_valid, command_tag_out, write_data_0_out, write_data_1_out
    );

endinterface

// File: rtl/write_command_control_free_tag_fifo.sv
// rtl/write_command_control_free_tag_fifo.sv - circular FIFO holding the free PSL command tags
module free_tag_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // Flags are registered, so a tag pushed into an empty FIFO only becomes visible next cycle.
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Tag storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and status flags.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            empty <= (count_next == '0);
            full  <= (count_next == DEPTH_W);
        end
    end

endmodule

// File: rtl/write_command_control.sv
// rtl/write_command_control.sv - tag/credit gated issue of cache-line write commands and data
module write_command_control
    import write_command_control_pkg::*;
#(
    parameter int TAGS    = 32,
    parameter int CREDITS = 64
) (
    input  logic                   clock,
    input  logic                   rstn,
    input  logic                   enabled_in,
    write_command_control_if.slave bus,
    output logic [8:0]             outstanding,
    output logic                   write_response_error,
    output logic                   protocol_error
);
    localparam int         TAG_AW    = $clog2(TAGS);
    localparam logic [8:0] TAGS_W    = 9'(TAGS);
    localparam logic [7:0] CREDITS_W = 8'(CREDITS);

    write_state_t             state;
    logic                     enabled_q;
    logic [8:0]               init_count;
    logic [7:0]               credits;
    logic [TAGS-1:0]          inflight;
    logic                     recycle_valid;
    logic [7:0]               recycle_tag;
    write_command_interface_t command_q;
    read_write_data_line_t    data_0_q;
    read_write_data_line_t    data_1_q;

    logic                     ready;
    logic                     accept;
    logic                     response_hit;
    logic                     response_miss;
    logic [TAG_AW-1:0]        head_index;
    logic [TAG_AW-1:0]        response_index;
    logic                     fifo_push;
    logic                     fifo_pop;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [7:0]               fifo_push_data;
    logic [7:0]               head_tag;

    // Ready depends only on registered state, never on req_valid.
    assign ready         = (state == RUN) && enabled_q && !fifo_empty && (credits != 8'd0);
    assign bus.req_ready = ready;
    assign accept        = bus.req_valid && ready;

    assign head_index     = head_tag[TAG_AW-1:0];
    assign response_index = bus.response_tag[TAG_AW-1:0];
    assign response_hit   = bus.response_valid && ({1'b0, bus.response_tag} < TAGS_W) && inflight[response_index];
    assign response_miss  = bus.response_valid && !response_hit;

    // INIT seeds the pool with 0..TAGS-1; afterwards only recycled tags are pushed, one cycle
    // after their response, which makes a freed tag poppable two cycles after the response.
    assign fifo_pop       = accept;
    assign fifo_push      = ((state == INIT) || recycle_valid) && !fifo_full;
    assign fifo_push_data = (state == INIT) ? init_count[7:0] : recycle_tag;

    free_tag_fifo #(
        .DEPTH (TAGS),
        .WIDTH (8)
    ) u_free_tags (
        .clock     (clock),
        .rstn      (rstn),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (head_tag),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // FSM, in-flight bookkeeping, credit/outstanding counters and registered command outputs.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state                <= INIT;
            enabled_q            <= 1'b0;
            init_count           <= '0;
            credits              <= CREDITS_W;
            inflight             <= '0;
            recycle_valid        <= 1'b0;
            recycle_tag          <= '0;
            command_q            <= '0;
            data_0_q             <= '0;
            data_1_q             <= '0;
            outstanding          <= '0;
            write_response_error <= 1'b0;
            protocol_error       <= 1'b0;
        end else begin
            enabled_q <= enabled_in;

            case (state)
                INIT: begin
                    init_count <= init_count + 9'd1;
                    if (init_count == TAGS_W - 9'd1) begin
                        state <= RUN;
                    end
                end
                default: begin
                    init_count <= '0;
                end
            endcase

            command_q.valid <= accept;
            if (accept) begin
                command_q.tag       <= head_tag;
                command_q.address   <= bus.req_address;
                command_q.size      <= CACHELINE_SIZE;
                data_0_q            <= bus.req_data_0;
                data_1_q            <= bus.req_data_1;
                inflight[head_index] <= 1'b1;
            end

            // A hit never names the tag popped this cycle: that tag was not in flight.
            if (response_hit) begin
                inflight[response_index] <= 1'b0;
            end
            recycle_valid        <= response_hit;
            recycle_tag          <= bus.response_tag;
            write_response_error <= response_hit && (bus.response_code != RESP_DONE);
            if (response_miss) begin
                protocol_error <= 1'b1;
            end

            if (accept && !response_hit) begin
                credits     <= credits - 8'd1;
                outstanding <= outstanding + 9'd1;
            end else if (!accept && response_hit) begin
                if (credits != CREDITS_W) begin
                    credits <= credits + 8'd1;
                end
                outstanding <= outstanding - 9'd1;
            end
        end
    end

    assign bus.command_valid       = command_q.valid;
    assign bus.command_tag         = command_q.tag;
    assign bus.command_address     = command_q.address;
    assign bus.command_size        = command_q.size;
    assign bus.command_write_valid = command_q.valid;
    assign bus.command_tag_out     = command_q.tag;
    assign bus.write_data_0_out    = data_0_q;
    assign bus.write_data_1_out    = data_1_q;

endmodule

// File: tb/tb_write_command_control.sv
// tb/tb_write_command_control.sv - randomized scoreboard bench for write_command_control
module tb_write_command_control;
    import write_command_control_pkg::*;

    localparam int TAGS    = 32;
    localparam int CREDITS = 64;

    logic       clock       = 1'b0;
    logic       rstn        = 1'b0;
    logic       enabled_in  = 1'b0;
    logic       enabled_in2 = 1'b0;
    logic [8:0] outstanding;
    logic [8:0] outstanding2;
    logic       wre;
    logic       perr;
    logic       wre2;
    logic       perr2;

    write_command_control_if bus();
    write_command_control_if bus2();

    write_command_control #(.TAGS(TAGS), .CREDITS(CREDITS)) dut (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in), .bus(bus),
        .outstanding(outstanding), .write_response_error(wre), .protocol_error(perr)
    );

    write_command_control #(.TAGS(8), .CREDITS(2)) dut2 (
        .clock(clock), .rstn(rstn), .enabled_in(enabled_in2), .bus(bus2),
        .outstanding(outstanding2), .write_response_error(wre2), .protocol_error(perr2)
    );

    always #5 clock = ~clock;

    typedef struct {
        int                    tag;
        logic [63:0]           address;
        read_write_data_line_t d0;
        read_write_data_line_t d1;
    } exp_cmd_t;

    typedef struct {
        bit cmd;
        bit err;
        bit perr;
        int outstanding;
    } exp_stat_t;

    exp_cmd_t  exp_q[$];
    exp_stat_t stat_q[$];
    exp_stat_t mon_s;
    exp_cmd_t  mon_e;
    int        checks   = 0;
    int        failures = 0;
    bit        mon_en   = 1'b0;

    // reference model: pool of poppable tags, delayed recycles, in-flight set, counters
    int free_q[$];
    int pend_tag[$];
    int pend_at[$];
    bit inflight_m[TAGS];
    int cyc;
    int credits_m;
    int out_m;
    bit perr_m;
    bit en_prev;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic read_write_data_line_t rand_line();
        read_write_data_line_t v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int pick_inflight();
        int c[$];
        for (int i = 0; i < TAGS; i++) if (inflight_m[i]) c.push_back(i);
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    task automatic model_reset();
        exp_q.delete();
        stat_q.delete();
        free_q.delete();
        pend_tag.delete();
        pend_at.delete();
        for (int i = 0; i < TAGS; i++) begin
            free_q.push_back(i);
            inflight_m[i] = 1'b0;
        end
        credits_m = CREDITS;
        out_m     = 0;
        perr_m    = 1'b0;
        en_prev   = 1'b0;
        cyc       = 0;
    endtask

    task automatic idle_inputs();
        bus.req_valid       = 1'b0;
        bus.req_address     = '0;
        bus.req_data_0      = '0;
        bus.req_data_1      = '0;
        bus.response_valid  = 1'b0;
        bus.response_tag    = '0;
        bus.response_code   = '0;
        bus2.req_valid      = 1'b0;
        bus2.req_address    = '0;
        bus2.req_data_0     = '0;
        bus2.req_data_1     = '0;
        bus2.response_valid = 1'b0;
        bus2.response_tag   = '0;
        bus2.response_code  = '0;
    endtask

    // one cycle: called at a negedge, drives inputs, predicts the outcome, waits for the next negedge
    task automatic step(input bit rv, input bit rsp_v, input int rtag, input logic [7:0] rcode, input bit en);
        bit          ready_m;
        bit          acc;
        bit          ok;
        int          t;
        logic [63:0] addr;
        exp_cmd_t    e;
        while (pend_at.size() > 0 && pend_at[0] <= cyc) begin
            free_q.push_back(pend_tag.pop_front());
            void'(pend_at.pop_front());
        end
        ready_m = (cyc >= TAGS) && en_prev && (free_q.size() > 0) && (credits_m > 0);
        check("req_ready", bus.req_ready, ready_m);
        ok = 1'b0;
        if (rsp_v && rtag >= 0 && rtag < TAGS) ok = inflight_m[rtag];
        acc = rv && ready_m;
        addr = {$urandom, $urandom};
        addr[6:0] = '0;
        bus.req_valid      = rv;
        bus.req_address    = addr;
        bus.req_data_0     = rand_line();
        bus.req_data_1     = rand_line();
        bus.response_valid = rsp_v;
        bus.response_tag   = 8'(rtag);
        bus.response_code  = rcode;
        enabled_in         = en;
        if (acc) begin
            t = free_q.pop_front();
            inflight_m[t] = 1'b1;
            credits_m--;
            out_m++;
            e.tag = t;
            e.address = addr;
            e.d0 = bus.req_data_0;
            e.d1 = bus.req_data_1;
            exp_q.push_back(e);
        end
        if (ok) begin
            inflight_m[rtag] = 1'b0;
            out_m--;
            if (credits_m < CREDITS) credits_m++;
            pend_tag.push_back(rtag);
            pend_at.push_back(cyc + 2);
        end else if (rsp_v) begin
            perr_m = 1'b1;
        end
        stat_q.push_back('{acc, ok && (rcode != 8'h00), perr_m, out_m});
        en_prev = en;
        @(negedge clock);
        cyc++;
    endtask

    // asserts reset at a negedge, checks every output cleared, then releases it and resets the model
    task automatic reset_check();
        mon_en = 1'b0;
        rstn   = 1'b0;
        idle_inputs();
        #1;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_command_valid", bus.command_valid, 0);
        check("rst_command_write_valid", bus.command_write_valid, 0);
        check("rst_command_tag", bus.command_tag, 0);
        check("rst_command_tag_out", bus.command_tag_out, 0);
        check("rst_command_address", bus.command_address, 0);
        check("rst_command_size", bus.command_size, 0);
        check("rst_write_data_0", bus.write_data_0_out, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_write_response_error", wre, 0);
        check("rst_protocol_error", perr, 0);
        @(negedge clock);
        @(negedge clock);
        model_reset();
        rstn   = 1'b1;
        mon_en = 1'b1;
    endtask

    // monitor: one time unit after each active edge, compare outputs with the queued expectations
    always @(posedge clock) begin
        #1;
        if (mon_en && stat_q.size() > 0) begin
            mon_s = stat_q.pop_front();
            check("command_valid", bus.command_valid, mon_s.cmd);
            check("command_write_valid", bus.command_write_valid, mon_s.cmd);
            check("write_response_error", wre, mon_s.err);
            check("protocol_error", perr, mon_s.perr);
            check("outstanding", outstanding, mon_s.outstanding);
            if (mon_s.cmd && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("command_tag", bus.command_tag, mon_e.tag);
                check("command_tag_out", bus.command_tag_out, mon_e.tag);
                check("command_address", bus.command_address, mon_e.address);
                check("command_size", bus.command_size, 128);
                check("write_data_0_out", bus.write_data_0_out, mon_e.d0);
                check("write_data_1_out", bus.write_data_1_out, mon_e.d1);
            end
        end
    end

    initial begin
        idle_inputs();
        enabled_in  = 1'b1;
        enabled_in2 = 1'b1;
        @(negedge clock);
        reset_check();

        // INIT window refuses everything, then tags 0..3 back to back
        for (int i = 0; i < TAGS; i++) step(1'($urandom_range(0, 1)), 0, 0, 8'h00, 1);
        repeat (4) step(1, 0, 0, 8'h00, 1);

        // exhaust the pool: 28 more accepts, the 33rd request is refused
        repeat (29) step(1, 0, 0, 8'h00, 1);

        // DONE for tag 5 makes it issuable two cycles later
        step(0, 1, 5, 8'h00, 1);
        repeat (3) step(1, 0, 0, 8'h00, 1);

        // free tag 9, then accept it in the same cycle as DONE for tag 7
        step(0, 1, 9, 8'h00, 1);
        step(0, 0, 0, 8'h00, 1);
        step(1, 1, 7, 8'h00, 1);

        // error response on tag 3, then responses for tags not in flight
        step(0, 1, 3, 8'h01, 1);
        step(0, 1, 20, 8'h00, 1);
        step(0, 1, 20, 8'h00, 1);
        step(0, 1, 200, 8'h00, 1);
        repeat (5) step(1, 0, 0, 8'h00, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int         t;
            bit         rv;
            bit         rs;
            bit         en;
            logic [7:0] code;
            rv = ($urandom_range(0, 3) != 0);
            t  = pick_inflight();
            rs = (t >= 0) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 39) == 0) begin
                rs = 1'b1;
                t  = $urandom_range(0, 255);
            end
            code = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            en   = ($urandom_range(0, 9) != 0);
            step(rv, rs, rs ? t : 0, code, en);
        end

        // settle at exactly 10 tags in flight, then reset mid-operation
        for (int k = 0; k < 200 && out_m != 10; k++) begin
            if (out_m > 10) step(0, 1, pick_inflight(), 8'h00, 1);
            else step(1, 0, 0, 8'h00, 1);
        end
        repeat (2) step(0, 0, 0, 8'h00, 1);
        check("outstanding_before_reset", outstanding, 10);
        reset_check();
        for (int i = 0; i < TAGS; i++) step(1'($urandom_range(0, 1)), 0, 0, 8'h00, 1);
        repeat (4) step(1, 0, 0, 8'h00, 1);
        repeat (3) step(0, 0, 0, 8'h00, 1);

        // credit-limited instance: CREDITS=2, TAGS=8
        check("c2_ready_initial", bus2.req_ready, 1);
        bus2.req_valid   = 1'b1;
        bus2.req_address = 64'h1000;
        @(negedge clock);
        check("c2_tag_first", bus2.command_tag, 0);
        check("c2_ready_one_credit", bus2.req_ready, 1);
        @(negedge clock);
        check("c2_tag_second", bus2.command_tag, 1);
        check("c2_ready_no_credit", bus2.req_ready, 0);
        check("c2_outstanding", outstanding2, 2);
        bus2.response_valid = 1'b1;
        bus2.response_tag   = 8'd0;
        bus2.response_code  = 8'h00;
        @(negedge clock);
        bus2.response_valid = 1'b0;
        check("c2_ready_restored", bus2.req_ready, 1);
        check("c2_outstanding_after_done", outstanding2, 1);
        @(negedge clock);
        bus2.req_valid = 1'b0;
        check("c2_tag_third", bus2.command_tag, 2);
        check("c2_command_valid", bus2.command_valid, 1);
        check("c2_protocol_error", perr2, 0);
        check("c2_write_response_error", wre2, 0);
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/write_command_control.md
# write_command_control

Issue stage directly upstream of the write-data buffer. It accepts cache-line write requests from the AFU engines, allocates a unique PSL command tag from a free-tag pool, and respects the PSL command credit count. It emits the write command toward the command arbiter and, in the same cycle, delivers both half-line data words with the allocated tag into the write-data buffer. Completed tags are recycled from the PSL response stream.

## Interface
Parameters:
- TAGS, 32: tag pool depth. Power of 2, ≤256. Tags are 0..TAGS-1.
- CREDITS, 64: initial PSL command credits (ha_croom). 8-bit counter.

Ports:
- clock  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- enabled_in  in  1  block enable; registered internally one cycle
- req_valid  in  1  write request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_address  in  64  effective address, 128B aligned
- req_data_0  in  512  half line 0
- req_data_1  in  512  half line 1
- command_valid  out  1  command to arbiter
- command_tag  out  8  allocated tag
- command_address  out  64  registered req_address
- command_size  out  12  always 128
- command_write_valid  out  1  data-buffer write strobe
- command_tag_out  out  8  data-buffer write address
- write_data_0_out  out  512  data-buffer half 0
- write_data_1_out  out  512  data-buffer half 1
- response_valid  in  1  PSL response valid
- response_tag  in  8  response tag
- response_code  in  8  PSL response code; 0x00 = DONE
- outstanding  out  9  tags currently in flight
- write_response_error  out  1  one-cycle pulse, non-DONE response
- protocol_error  out  1  sticky; response for a tag that is not in flight

## Operation
- FSM states: INIT, RUN.
- INIT: entered on reset. Counter pushes tags 0..TAGS-1 into the free FIFO, one per cycle, then moves to RUN. req_ready=0 throughout.
- RUN: req_ready = enabled && free FIFO not empty && credits>0.
- Accept: pop head tag, set inflight[tag], decrement credits, register address and data.
- Response with inflight[response_tag]=1: clear the bit, push the tag to the free FIFO, increment credits.
  - code≠0x00 additionally pulses write_response_error. The tag is still freed; there is no retry.
- Response with inflight[response_tag]=0, or response_tag≥TAGS: set protocol_error. No push, no credit change.
- Accept and response in the same cycle: push and pop both occur, credits and outstanding are unchanged net. Pushing into an empty FIFO does not make the tag poppable until the next cycle.
- Credits saturate at CREDITS. Outstanding = number of set inflight bits, maintained as an up/down counter.
- enabled low: no new accepts. Responses are still processed.

## Timing
- Reset values: all outputs 0; credits=CREDITS; FIFO empty; state INIT.
- INIT lasts exactly TAGS cycles after rstn deasserts. req_ready can first be 1 on cycle TAGS+1, subject to the enable register.
- Latency: accept in cycle N produces command_valid and command_write_valid high together in cycle N+1, for exactly one cycle, with identical tags.
- Sustained throughput: one request per cycle while tags and credits remain.
- req_ready is combinational from registered state only; it never depends on req_valid.
- write_response_error asserts in the cycle after the response. A tag freed by response in cycle N is poppable in cycle N+2.
- Reset mid-operation: all in-flight state is discarded and the block re-enters INIT.

## Structure
- Shared package holds:
  - ReadWriteDataLine (512-bit).
  - WriteCommandInterface struct (valid, tag, address, size).
  - RESP_DONE constant.
  - CACHELINE_SIZE = 128.
- Sub-module: free_tag_fifo (depth TAGS, width 8, push/pop/empty/full, registered outputs).

## Test plan
- Reset, TAGS=32: req_ready stays 0 for 32 cycles, then 1. The first four back-to-back accepts get tags 0,1,2,3 on both command_tag and command_tag_out, one cycle later each.
- 32 accepts with no responses: req_ready=0 at the 33rd request, outstanding=32. DONE for tag 5 makes tag 5 issued two cycles later.
- CREDITS=2: two accepts, then req_ready=0 although tags are free. One DONE restores req_ready.
- Same-cycle accept and DONE for tag 7: outstanding unchanged, credits unchanged.
- Response code 0x01 for tag 3: write_response_error pulses once and tag 3 is recycled. A response for tag 20 that is not in flight sets protocol_error sticky.
- rstn asserted with 10 tags in flight: all outputs return to 0 and INIT reruns. Afterwards tags restart at 0.
